// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-side bundle for the iterative multiply/divide unit.
// master = pipeline/hazard side, slave = ex_muldiv_unit.
interface ex_muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_DR1;
  logic [WIDTH-1:0] in_DR2;
  logic             in_flush;
  logic [WIDTH-1:0] out_result;
  logic [WIDTH-1:0] out_hi;
  logic [WIDTH-1:0] out_lo;
  logic             out_busy;
  logic             out_stall;
  logic             out_done;

  modport master (
    output in_op, in_DR1, in_DR2, in_flush,
    input  out_result, out_hi, out_lo, out_busy, out_stall, out_done
  );

  modport slave (
    input  in_op, in_DR1, in_DR2, in_flush,
    output out_result, out_hi, out_lo, out_busy, out_stall, out_done
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO with MFHI/MFLO reads.
// One iteration per cycle, then a sign-fix cycle that writes HI/LO.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic             clk,
  input logic             rst_n,
  ex_muldiv_unit_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [2:0] OpMult  = 3'b001;
  localparam logic [2:0] OpMultu = 3'b010;
  localparam logic [2:0] OpDiv   = 3'b011;
  localparam logic [2:0] OpDivu  = 3'b100;
  localparam logic [2:0] OpMfhi  = 3'b101;
  localparam logic [2:0] OpMflo  = 3'b110;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e           state;
  logic [CntW-1:0]  cnt;
  logic [WIDTH-1:0] hiReg, loReg;
  // acc: product high half / partial remainder; qr: multiplier / quotient
  logic [WIDTH-1:0] acc, qr, opnd;
  logic             isDiv, negRes, negRem, busy, done;

  logic             isMulDiv, isSigned, isDivOp, accept;
  logic [WIDTH-1:0] absA, absB;
  logic [WIDTH:0]   mulSum, divTmp, divDiff;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0] quotFix, remFix;

  always_comb begin
    isMulDiv = bus.in_op inside {OpMult, OpMultu, OpDiv, OpDivu};
    isSigned = (bus.in_op == OpMult) || (bus.in_op == OpDiv);
    isDivOp  = (bus.in_op == OpDiv) || (bus.in_op == OpDivu);
    accept   = (state == StIdle) && isMulDiv && !bus.in_flush;
    absA     = (isSigned && bus.in_DR1[WIDTH-1]) ? -bus.in_DR1 : bus.in_DR1;
    absB     = (isSigned && bus.in_DR2[WIDTH-1]) ? -bus.in_DR2 : bus.in_DR2;
    mulSum   = {1'b0, acc} + {1'b0, (qr[0] ? opnd : {WIDTH{1'b0}})};
    divTmp   = {acc, qr[WIDTH-1]};
    divDiff  = divTmp - {1'b0, opnd};
    prodFix  = negRes ? -{acc, qr} : {acc, qr};
    quotFix  = negRes ? -qr : qr;
    remFix   = negRem ? -acc : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= StIdle;
      cnt    <= '0;
      hiReg  <= '0;
      loReg  <= '0;
      acc    <= '0;
      qr     <= '0;
      opnd   <= '0;
      isDiv  <= 1'b0;
      negRes <= 1'b0;
      negRem <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (accept) begin
            isDiv  <= isDivOp;
            negRes <= isSigned && (bus.in_DR1[WIDTH-1] ^ bus.in_DR2[WIDTH-1]);
            negRem <= isSigned && bus.in_DR1[WIDTH-1];
            acc    <= '0;
            qr     <= isDivOp ? absA : absB;
            opnd   <= isDivOp ? absB : absA;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= StRun;
          end
        end
        StRun: begin
          if (bus.in_flush) begin
            busy  <= 1'b0;
            state <= StIdle;
          end else begin
            if (isDiv) begin
              // Restoring step: keep the subtraction only if it did not borrow
              if (!divDiff[WIDTH]) begin
                acc <= divDiff[WIDTH-1:0];
                qr  <= {qr[WIDTH-2:0], 1'b1};
              end else begin
                acc <= divTmp[WIDTH-1:0];
                qr  <= {qr[WIDTH-2:0], 1'b0};
              end
            end else begin
              acc <= mulSum[WIDTH:1];
              qr  <= {mulSum[0], qr[WIDTH-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CntW'(WIDTH - 1)) begin
              state <= StFix;
            end
          end
        end
        StFix: begin
          busy  <= 1'b0;
          state <= StIdle;
          if (!bus.in_flush) begin
            done <= 1'b1;
            if (isDiv) begin
              // Divide by zero: quotient all ones, remainder is the raw dividend
              loReg <= (opnd == '0) ? {WIDTH{1'b1}} : quotFix;
              hiReg <= remFix;
            end else begin
              hiReg <= prodFix[2*WIDTH-1:WIDTH];
              loReg <= prodFix[WIDTH-1:0];
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.out_hi    = hiReg;
    bus.out_lo    = loReg;
    bus.out_busy  = busy;
    bus.out_done  = done;
    bus.out_stall = busy | (isMulDiv & busy);
    case (bus.in_op)
      OpMfhi:  bus.out_result = hiReg;
      OpMflo:  bus.out_result = loReg;
      default: bus.out_result = '0;
    endcase
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected HI/LO queued at issue,
// checked by a monitor on every out_done pulse.
module tb_ex_muldiv_unit;
  localparam int unsigned W = 32;

  localparam logic [2:0] OpNone  = 3'b000;
  localparam logic [2:0] OpMult  = 3'b001;
  localparam logic [2:0] OpMultu = 3'b010;
  localparam logic [2:0] OpDiv   = 3'b011;
  localparam logic [2:0] OpDivu  = 3'b100;
  localparam logic [2:0] OpMfhi  = 3'b101;
  localparam logic [2:0] OpMflo  = 3'b110;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ex_muldiv_unit_if #(.WIDTH(W)) bus ();
  ex_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_done) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got pulse with hi=%h lo=%h, want no pulse",
                   bus.out_hi, bus.out_lo);
        end else begin
          e = sb.pop_front();
          check({e.name, "_hi"}, bus.out_hi, e.hi);
          check({e.name, "_lo"}, bus.out_lo, e.lo);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running, want finish");
    $fatal(1, "watchdog expired");
  end

  // Present an op for one cycle; returns 1ns after the edge that samples it.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic flush);
    @(posedge clk);
    #1;
    bus.in_op    = op;
    bus.in_DR1   = a;
    bus.in_DR2   = b;
    bus.in_flush = flush;
    @(posedge clk);
    #1;
    bus.in_op    = OpNone;
    bus.in_flush = 1'b0;
  endtask

  // Returns at the first falling edge with out_busy low.
  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (bus.out_busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (bus.out_busy) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, want 0", name, n);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] hi, input logic [W-1:0] lo);
    sb.push_back('{name, hi, lo});
    issue(op, a, b, 1'b0);
    wait_idle(name);
  endtask

  initial begin : stim
    int n;
    int stallBad;

    bus.in_op    = OpMfhi;
    bus.in_DR1   = '0;
    bus.in_DR2   = '0;
    bus.in_flush = 1'b0;

    #2;
    check("rst_busy", W'(bus.out_busy), '0);
    check("rst_done", W'(bus.out_done), '0);
    check("rst_stall", W'(bus.out_stall), '0);
    check("rst_hi", bus.out_hi, '0);
    check("rst_lo", bus.out_lo, '0);
    check("rst_result", bus.out_result, '0);
    #20;
    rst_n = 1'b1;
    bus.in_op = OpNone;

    // MULTU 7 x 6: latency and busy width
    sb.push_back('{"multu_7x6", 32'h0, 32'h2A});
    issue(OpMultu, 32'd7, 32'd6, 1'b0);
    n = 0;
    @(negedge clk);
    while (bus.out_busy && n < 60) begin
      n++;
      @(negedge clk);
    end
    check("multu_busy_cycles", n, 33);
    check("multu_done_pulse", W'(bus.out_done), 32'd1);
    @(negedge clk);
    check("multu_done_one_cycle", W'(bus.out_done), '0);

    // MULT -3 x 5 then MFLO
    run_op("mult_m3x5", OpMult, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    bus.in_op = OpMflo;
    #1;
    check("mflo_result", bus.out_result, 32'hFFFF_FFF1);
    check("mflo_stall", W'(bus.out_stall), '0);
    bus.in_op = OpNone;

    run_op("div_m7d2", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7dm2", OpDiv, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD);
    run_op("divu_10d0", OpDivu, 32'd10, 32'd0, 32'hA, 32'hFFFF_FFFF);
    run_op("div_m7d0", OpDiv, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // MFHI issued while a MULTU is in flight must stall until busy falls
    sb.push_back('{"multu_ffxff", 32'hFFFF_FFFE, 32'h0000_0001});
    issue(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(posedge clk);
    #1;
    bus.in_op = OpMfhi;
    n = 0;
    stallBad = 0;
    @(negedge clk);
    while (bus.out_busy && n < 60) begin
      if (!bus.out_stall) stallBad++;
      n++;
      @(negedge clk);
    end
    check("mfhi_stall_while_busy", stallBad, 0);
    check("mfhi_busy_cycles_seen", n, 32);
    check("mfhi_stall_released", W'(bus.out_stall), '0);
    check("mfhi_result", bus.out_result, 32'hFFFF_FFFE);
    bus.in_op = OpNone;

    // Flush in RUN leaves HI/LO untouched and produces no done
    run_op("divu_seed", OpDivu, 32'h451, 32'h20, 32'h11, 32'h22);
    issue(OpDivu, 32'd100, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    bus.in_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.in_flush = 1'b0;
    @(negedge clk);
    check("flush_run_idle", W'(bus.out_busy), '0);
    repeat (40) @(negedge clk);
    check("flush_run_hi", bus.out_hi, 32'h11);
    check("flush_run_lo", bus.out_lo, 32'h22);

    // Flush with MULT in IDLE: nothing accepted
    issue(OpMult, 32'd3, 32'd3, 1'b1);
    @(negedge clk);
    check("flush_idle_busy", W'(bus.out_busy), '0);
    repeat (40) @(negedge clk);
    check("flush_idle_hi", bus.out_hi, 32'h11);
    check("flush_idle_lo", bus.out_lo, 32'h22);

    // Asynchronous reset mid-MULT
    issue(OpMult, 32'd5, 32'd5, 1'b0);
    repeat (14) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", W'(bus.out_busy), '0);
    check("async_rst_hi", bus.out_hi, '0);
    check("async_rst_lo", bus.out_lo, '0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    run_op("multu_3x4", OpMultu, 32'd3, 32'd4, 32'h0, 32'd12);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
